coeff_seq_ctrl: RTL and testbench

COEFF_SEQ_CTRL -- requirements
Module: coeff_seq_ctrl

---
 rtl/coeff_seq_ctrl_if.sv | 34 +++
 rtl/coeff_seq_ctrl.sv | 117 +++++++++++
 tb/tb_coeff_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/coeff_seq_ctrl_if.sv
// Bus between the coefficient sequencer and its serial-write master / coefficient banks.
// The master drives sweep requests and coefficient writes. The slave (the sequencer) drives memory controls and tap markers.
interface coeff_seq_ctrl_if #(
  parameter int AW_R = 6
) ();
  logic            sample_strobe;
  logic            wr_req;
  logic [8:0]      wr_addr;
  logic [35:0]     wr_data;
  logic            wr_ack;
  logic            clear_overrun;
  logic [AW_R-1:0] mem_addressR;
  logic [8:0]      mem_addressW;
  logic [35:0]     mem_datain;
  logic            mem_we;
  logic            tap_valid;
  logic [5:0]      tap_index;
  logic            tap_first;
  logic            tap_last;
  logic            busy;
  logic            overrun;

  modport master (
    output sample_strobe, wr_req, wr_addr, wr_data, clear_overrun,
    input  wr_ack, mem_addressR, mem_addressW, mem_datain, mem_we,
           tap_valid, tap_index, tap_first, tap_last, busy, overrun
  );

  modport slave (
    input  sample_strobe, wr_req, wr_addr, wr_data, clear_overrun,
    output wr_ack, mem_addressR, mem_addressW, mem_datain, mem_we,
           tap_valid, tap_index, tap_first, tap_last, busy, overrun
  );
endinterface

// File: rtl/coeff_seq_ctrl.sv
// Sweeps the coefficient-bank read address once per sample and tags the delayed taps.
// Serial coefficient writes are held off until the sequencer is idle, so a sweep never sees a coefficient change.
module coeff_seq_ctrl #(
  parameter int LAST_ADDR = 63,
  parameter int AW_R      = 6
) (
  input logic             clock,
  input logic             reset,
  coeff_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH} state_e;

  localparam logic [AW_R-1:0] LastAddr = AW_R'(LAST_ADDR);

  state_e          state_q, state_d;
  logic [AW_R-1:0] addr_r_q, addr_r_d;
  logic [8:0]      addr_w_q, addr_w_d;
  logic [35:0]     data_w_q, data_w_d;
  logic            we_q, we_d;
  logic            ack_q, ack_d;
  logic            tap_valid_q, tap_valid_d;
  logic [5:0]      tap_index_q, tap_index_d;
  logic            tap_first_q, tap_first_d;
  logic            tap_last_q, tap_last_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            in_sweep;

  assign in_sweep = (state_q == SWEEP);

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    addr_r_d  = '0;
    addr_w_d  = addr_w_q;
    data_w_d  = data_w_q;
    we_d      = 1'b0;
    ack_d     = 1'b0;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: begin
        // A strobe beats a write in the same cycle; wr_req stays high and is taken after the sweep.
        if (bus.sample_strobe) begin
          state_d = SWEEP;
        end else if (bus.wr_req && !ack_q) begin
          we_d     = 1'b1;
          ack_d    = 1'b1;
          addr_w_d = bus.wr_addr;
          data_w_d = bus.wr_data;
        end
      end
      SWEEP: begin
        if (addr_r_q == LastAddr) state_d = FLUSH;
        else                      addr_r_d = addr_r_q + AW_R'(1);
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The banks have one cycle of read latency, so taps trail the read address by one cycle.
    tap_valid_d = in_sweep;
    tap_index_d = in_sweep ? 6'(addr_r_q) : 6'd0;
    tap_first_d = in_sweep && (addr_r_q == '0);
    tap_last_d  = in_sweep && (addr_r_q == LastAddr);
    busy_d      = (state_d != IDLE);

    // Set takes precedence over clear.
    if (bus.sample_strobe && (state_q != IDLE)) overrun_d = 1'b1;
    else if (bus.clear_overrun)                 overrun_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_r_q    <= '0;
      addr_w_q    <= '0;
      data_w_q    <= '0;
      we_q        <= 1'b0;
      ack_q       <= 1'b0;
      tap_valid_q <= 1'b0;
      tap_index_q <= '0;
      tap_first_q <= 1'b0;
      tap_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_r_q    <= addr_r_d;
      addr_w_q    <= addr_w_d;
      data_w_q    <= data_w_d;
      we_q        <= we_d;
      ack_q       <= ack_d;
      tap_valid_q <= tap_valid_d;
      tap_index_q <= tap_index_d;
      tap_first_q <= tap_first_d;
      tap_last_q  <= tap_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.mem_addressR = addr_r_q;
  assign bus.mem_addressW = addr_w_q;
  assign bus.mem_datain   = data_w_q;
  assign bus.mem_we       = we_q;
  assign bus.wr_ack       = ack_q;
  assign bus.tap_valid    = tap_valid_q;
  assign bus.tap_index    = tap_index_q;
  assign bus.tap_first    = tap_first_q;
  assign bus.tap_last     = tap_last_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_coeff_seq_ctrl.sv
// Directed bench for coeff_seq_ctrl: the taps and writes the DUT should produce are queued as stimulus is driven.
// A negedge monitor pops each queue entry as the DUT produces the matching tap or write.
module tb_coeff_seq_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  coeff_seq_ctrl_if #(.AW_R(6)) bus  ();
  coeff_seq_ctrl_if #(.AW_R(6)) bus0 ();

  coeff_seq_ctrl #(.LAST_ADDR(63), .AW_R(6)) u_dut  (.clock(clock), .reset(reset), .bus(bus));
  coeff_seq_ctrl #(.LAST_ADDR(0),  .AW_R(6)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));

  typedef struct packed {
    logic [5:0] idx;
    logic       first;
    logic       last;
  } tap_t;

  typedef struct packed {
    logic [8:0]  addr;
    logic [35:0] data;
  } wr_t;

  tap_t tap_q[$];
  wr_t  wr_q[$];
  tap_t mon_tap;
  wr_t  mon_wr;
  int   total = 0;
  int   bad   = 0;
  int   n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_sweep();
    for (int i = 0; i <= 63; i++) tap_q.push_back('{idx: 6'(i), first: (i == 0), last: (i == 63)});
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_addrR"},   64'(bus.mem_addressR), 64'd0);
    check({pfx, "_addrW"},   64'(bus.mem_addressW), 64'd0);
    check({pfx, "_datain"},  64'(bus.mem_datain),   64'd0);
    check({pfx, "_we"},      64'(bus.mem_we),       64'd0);
    check({pfx, "_ack"},     64'(bus.wr_ack),       64'd0);
    check({pfx, "_tvalid"},  64'(bus.tap_valid),    64'd0);
    check({pfx, "_tindex"},  64'(bus.tap_index),    64'd0);
    check({pfx, "_tfirst"},  64'(bus.tap_first),    64'd0);
    check({pfx, "_tlast"},   64'(bus.tap_last),     64'd0);
    check({pfx, "_busy"},    64'(bus.busy),         64'd0);
    check({pfx, "_overrun"}, 64'(bus.overrun),      64'd0);
  endtask

  // Scoreboard side: every tap and every write the DUT emits must match the next queued expectation.
  always @(negedge clock) begin
    if (bus.tap_valid === 1'b1) begin
      if (tap_q.size() == 0) begin
        check("tap_unexpected", 64'(bus.tap_valid), 64'd0);
      end else begin
        mon_tap = tap_q.pop_front();
        check("tap_index", 64'(bus.tap_index), 64'(mon_tap.idx));
        check("tap_first", 64'(bus.tap_first), 64'(mon_tap.first));
        check("tap_last",  64'(bus.tap_last),  64'(mon_tap.last));
      end
    end
    if (bus.mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("we_unexpected", 64'(bus.mem_we), 64'd0);
      end else begin
        mon_wr = wr_q.pop_front();
        check("we_addrW",  64'(bus.mem_addressW), 64'(mon_wr.addr));
        check("we_datain", 64'(bus.mem_datain),   64'(mon_wr.data));
        check("we_ack",    64'(bus.wr_ack),       64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.sample_strobe  = 1'b0;
    bus.wr_req         = 1'b0;
    bus.wr_addr        = '0;
    bus.wr_data        = '0;
    bus.clear_overrun  = 1'b0;
    bus0.sample_strobe = 1'b0;
    bus0.wr_req        = 1'b0;
    bus0.wr_addr       = '0;
    bus0.wr_data       = '0;
    bus0.clear_overrun = 1'b0;

    // Reset state
    step();
    step();
    check_zero("rst");
    check("rst_busy0", 64'(bus0.busy), 64'd0);
    reset = 1'b0;
    step();

    // Single write from idle; wr_req held through the ack cycle must not write twice
    bus.wr_addr = 9'h041;
    bus.wr_data = 36'h123456789;
    bus.wr_req  = 1'b1;
    wr_q.push_back('{addr: 9'h041, data: 36'h123456789});
    step();
    check("w_we",     64'(bus.mem_we),       64'd1);
    check("w_ack",    64'(bus.wr_ack),       64'd1);
    check("w_addrW",  64'(bus.mem_addressW), 64'h041);
    check("w_datain", 64'(bus.mem_datain),   64'h123456789);
    step();
    check("w_we_once",  64'(bus.mem_we), 64'd0);
    check("w_ack_once", 64'(bus.wr_ack), 64'd0);
    bus.wr_req = 1'b0;
    step();
    check("w_addrW_hold",  64'(bus.mem_addressW), 64'h041);
    check("w_datain_hold", 64'(bus.mem_datain),   64'h123456789);
    check("w_we_idle",     64'(bus.mem_we),       64'd0);

    // Full sweep: strobe sampled at edge 0
    push_sweep();
    bus.sample_strobe = 1'b1;
    step();
    bus.sample_strobe = 1'b0;
    check("A_busy0",  64'(bus.busy),         64'd1);
    check("A_addrR0", 64'(bus.mem_addressR), 64'd0);
    check("A_tv0",    64'(bus.tap_valid),    64'd0);
    for (int e = 1; e <= 66; e++) begin
      step();
      check("A_busy",  64'(bus.busy),         64'(e <= 64));
      check("A_tv",    64'(bus.tap_valid),    64'(e <= 64));
      check("A_addrR", 64'(bus.mem_addressR), (e <= 63) ? 64'(e) : 64'd0);
    end
    check("A_taps_left", 64'(tap_q.size()), 64'd0);
    check("A_overrun",   64'(bus.overrun),  64'd0);

    // Sweep with a strobe at edge 10, set+clear at edge 30, write requested mid-sweep
    push_sweep();
    bus.sample_strobe = 1'b1;
    step();
    bus.sample_strobe = 1'b0;
    for (int e = 1; e <= 9; e++) step();
    bus.sample_strobe = 1'b1;
    step();
    bus.sample_strobe = 1'b0;
    check("B_overrun_set", 64'(bus.overrun),      64'd1);
    check("B_no_restart",  64'(bus.mem_addressR), 64'd10);
    for (int e = 11; e <= 67; e++) begin
      if (e == 20) begin
        bus.wr_addr = 9'h1ab;
        bus.wr_data = 36'hfedcba987;
        bus.wr_req  = 1'b1;
        wr_q.push_back('{addr: 9'h1ab, data: 36'hfedcba987});
      end
      if (e == 30) begin
        bus.sample_strobe = 1'b1;
        bus.clear_overrun = 1'b1;
      end
      step();
      bus.sample_strobe = 1'b0;
      bus.clear_overrun = 1'b0;
      if (e == 30) check("B_set_wins", 64'(bus.overrun), 64'd1);
      check("B_busy",    64'(bus.busy),   64'(e <= 64));
      check("B_we_hold", 64'(bus.mem_we), 64'(e == 66));
      if (e == 66) bus.wr_req = 1'b0;
    end
    check("B_overrun_sticky", 64'(bus.overrun), 64'd1);
    bus.clear_overrun = 1'b1;
    step();
    bus.clear_overrun = 1'b0;
    check("B_overrun_clr", 64'(bus.overrun),  64'd0);
    check("B_taps_left",   64'(tap_q.size()), 64'd0);
    check("B_wr_left",     64'(wr_q.size()),  64'd0);

    // Strobe and write in the same idle cycle: sweep first, write after
    push_sweep();
    wr_q.push_back('{addr: 9'h0ff, data: 36'h0a5a5a5a5});
    bus.wr_addr       = 9'h0ff;
    bus.wr_data       = 36'h0a5a5a5a5;
    bus.wr_req        = 1'b1;
    bus.sample_strobe = 1'b1;
    step();
    bus.sample_strobe = 1'b0;
    check("C_busy", 64'(bus.busy),   64'd1);
    check("C_we0",  64'(bus.mem_we), 64'd0);
    n = 0;
    while (bus.mem_we !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    bus.wr_req = 1'b0;
    check("C_we_edge",   64'(n),            64'd66);
    check("C_taps_left", 64'(tap_q.size()), 64'd0);

    // Reset at edge 20 of a sweep, with strobe and write pending at the reset edge
    push_sweep();
    bus.sample_strobe = 1'b1;
    step();
    bus.sample_strobe = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      bus.sample_strobe = (e == 5);
      step();
    end
    bus.sample_strobe = 1'b0;
    check("R_overrun_pre", 64'(bus.overrun), 64'd1);
    reset             = 1'b1;
    bus.sample_strobe = 1'b1;
    bus.wr_addr       = 9'h155;
    bus.wr_data       = 36'h5a5a5a5a5;
    bus.wr_req        = 1'b1;
    step();
    tap_q.delete();
    check_zero("R");
    reset             = 1'b0;
    bus.sample_strobe = 1'b0;
    bus.wr_req        = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("R_tv_quiet",   64'(bus.tap_valid), 64'd0);
      check("R_busy_quiet", 64'(bus.busy),      64'd0);
    end
    push_sweep();
    bus.sample_strobe = 1'b1;
    step();
    bus.sample_strobe = 1'b0;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check("R_sweep_len", 64'(n), 64'd65);
    step();
    check("R_taps_left", 64'(tap_q.size()), 64'd0);
    check("R_wr_left",   64'(wr_q.size()),  64'd0);

    // Single-entry sweep (LAST_ADDR = 0)
    bus0.sample_strobe = 1'b1;
    step();
    bus0.sample_strobe = 1'b0;
    check("Z_busy0",  64'(bus0.busy),         64'd1);
    check("Z_addrR0", 64'(bus0.mem_addressR), 64'd0);
    check("Z_tv0",    64'(bus0.tap_valid),    64'd0);
    step();
    check("Z_busy1",  64'(bus0.busy),      64'd1);
    check("Z_tv1",    64'(bus0.tap_valid), 64'd1);
    check("Z_idx1",   64'(bus0.tap_index), 64'd0);
    check("Z_first1", 64'(bus0.tap_first), 64'd1);
    check("Z_last1",  64'(bus0.tap_last),  64'd1);
    step();
    check("Z_busy2", 64'(bus0.busy),      64'd0);
    check("Z_tv2",   64'(bus0.tap_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
